// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: free-running pixel/line counters feeding the draw chain, with
// blank/sync delayed to line up with the colour the drawers return, all registered at the pins.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter int unsigned RGB_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rgb_in,
  output logic [10:0] pixelX,
  output logic [10:0] pixelY,
  output logic        startOfFrame,
  output logic        endOfLine,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blankN
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] HLast      = 11'(H_TOTAL - 1);
  localparam logic [10:0] VLast      = 11'(V_TOTAL - 1);
  localparam logic [10:0] HAct       = 11'(H_ACTIVE);
  localparam logic [10:0] VAct       = 11'(V_ACTIVE);
  localparam logic [10:0] HSyncStart = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HSyncEnd   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VSyncStart = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VSyncEnd   = 11'(V_ACTIVE + V_FP + V_SYNC);

  // Timing bundle {active, hs, vs}; the idle value keeps both syncs deasserted.
  localparam logic [2:0] TimIdle = 3'b011;

  logic [10:0] hcnt_q, hcnt_d;
  logic [10:0] vcnt_q, vcnt_d;

  always_comb begin
    hcnt_d = hcnt_q + 11'd1;
    vcnt_d = vcnt_q;
    if (hcnt_q == HLast) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == VLast) ? '0 : vcnt_q + 11'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  assign pixelX       = hcnt_q;
  assign pixelY       = vcnt_q;
  assign startOfFrame = (hcnt_q == '0) && (vcnt_q == '0);
  assign endOfLine    = (hcnt_q == HLast);

  logic [2:0] tim_raw;
  logic [2:0] tim_dly;

  always_comb begin
    tim_raw[2] = (hcnt_q < HAct) && (vcnt_q < VAct);
    tim_raw[1] = ~((hcnt_q >= HSyncStart) && (hcnt_q < HSyncEnd));
    tim_raw[0] = ~((vcnt_q >= VSyncStart) && (vcnt_q < VSyncEnd));
  end

  // Delay timing by the draw-chain latency so it meets the matching rgb_in.
  if (RGB_LATENCY == 0) begin : g_bypass
    assign tim_dly = tim_raw;
  end else begin : g_pipe
    logic [2:0] pipe_q [RGB_LATENCY];

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < int'(RGB_LATENCY); i++) begin
          pipe_q[i] <= TimIdle;
        end
      end else begin
        pipe_q[0] <= tim_raw;
        for (int i = 1; i < int'(RGB_LATENCY); i++) begin
          pipe_q[i] <= pipe_q[i-1];
        end
      end
    end

    assign tim_dly = pipe_q[RGB_LATENCY-1];
  end

  logic [3:0] r_q, g_q, b_q;
  logic       hs_q, vs_q, blank_n_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_n_q <= 1'b0;
    end else begin
      r_q       <= tim_dly[2] ? {rgb_in[7:5], rgb_in[7]}   : 4'h0;
      g_q       <= tim_dly[2] ? {rgb_in[4:2], rgb_in[4]}   : 4'h0;
      b_q       <= tim_dly[2] ? {rgb_in[1:0], rgb_in[1:0]} : 4'h0;
      hs_q      <= tim_dly[1];
      vs_q      <= tim_dly[0];
      blank_n_q <= tim_dly[2];
    end
  end

  assign vga_r      = r_q;
  assign vga_g      = g_q;
  assign vga_b      = b_q;
  assign vga_hs     = hs_q;
  assign vga_vs     = vs_q;
  assign vga_blankN = blank_n_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-size instance at latency 1 plus two small-raster instances at
// latencies 0 and 3, all checked each clock against an arithmetic raster model.
module tb_vga_timing_gen;

  typedef logic [38:0] vec_t;  // {x, y, sof, eol, r, g, b, hs, vs, blankN}

  typedef struct {
    int ha, hfp, hsw, hbp, va, vfp, vsw, vbp, lat;
  } geo_t;

  logic       clk;
  logic       reset;
  logic [7:0] rgb_in;

  logic [10:0] m_px, m_py, s0_px, s0_py, s3_px, s3_py;
  logic        m_sof, m_eol, s0_sof, s0_eol, s3_sof, s3_eol;
  logic [3:0]  m_r, m_g, m_b, s0_r, s0_g, s0_b, s3_r, s3_g, s3_b;
  logic        m_hs, m_vs, m_bl, s0_hs, s0_vs, s0_bl, s3_hs, s3_vs, s3_bl;

  vga_timing_gen u_dut (
    .clk(clk), .reset(reset), .rgb_in(rgb_in), .pixelX(m_px), .pixelY(m_py),
    .startOfFrame(m_sof), .endOfLine(m_eol), .vga_r(m_r), .vga_g(m_g), .vga_b(m_b),
    .vga_hs(m_hs), .vga_vs(m_vs), .vga_blankN(m_bl)
  );

  vga_timing_gen #(
    .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .RGB_LATENCY(0)
  ) u_small0 (
    .clk(clk), .reset(reset), .rgb_in(rgb_in), .pixelX(s0_px), .pixelY(s0_py),
    .startOfFrame(s0_sof), .endOfLine(s0_eol), .vga_r(s0_r), .vga_g(s0_g), .vga_b(s0_b),
    .vga_hs(s0_hs), .vga_vs(s0_vs), .vga_blankN(s0_bl)
  );

  vga_timing_gen #(
    .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .RGB_LATENCY(3)
  ) u_small3 (
    .clk(clk), .reset(reset), .rgb_in(rgb_in), .pixelX(s3_px), .pixelY(s3_py),
    .startOfFrame(s3_sof), .endOfLine(s3_eol), .vga_r(s3_r), .vga_g(s3_g), .vga_b(s3_b),
    .vga_hs(s3_hs), .vga_vs(s3_vs), .vga_blankN(s3_bl)
  );

  vec_t obs_m, obs_s0, obs_s3;
  assign obs_m  = {m_px, m_py, m_sof, m_eol, m_r, m_g, m_b, m_hs, m_vs, m_bl};
  assign obs_s0 = {s0_px, s0_py, s0_sof, s0_eol, s0_r, s0_g, s0_b, s0_hs, s0_vs, s0_bl};
  assign obs_s3 = {s3_px, s3_py, s3_sof, s3_eol, s3_r, s3_g, s3_b, s3_hs, s3_vs, s3_bl};

  initial clk = 1'b0;
  always #20 clk = ~clk;

  int   tests, fails;
  int   tick;  // clocks since the last reset edge
  int   hs_run, vs_run0, vs_run3, sof_last0, sof_last3;
  int   cnt_f, cnt_0;
  geo_t gm, gs0, gs3;

  // Pins at tick t show the coordinate of tick t-lat-1 and the rgb_in present at the last edge.
  function automatic vec_t model(input geo_t g, input int t, input logic [7:0] rgb);
    int ht, vt, x, y, c, cx, cy;
    logic sof, eol, act, hs, vs, bl;
    logic [3:0] rr, gc, bb;
    ht  = g.ha + g.hfp + g.hsw + g.hbp;
    vt  = g.va + g.vfp + g.vsw + g.vbp;
    x   = t % ht;
    y   = (t / ht) % vt;
    sof = (x == 0) && (y == 0);
    eol = (x == ht - 1);
    c   = t - g.lat - 1;
    rr = 4'h0; gc = 4'h0; bb = 4'h0; hs = 1'b1; vs = 1'b1; bl = 1'b0;
    if (c >= 0) begin
      cx  = c % ht;
      cy  = (c / ht) % vt;
      act = (cx < g.ha) && (cy < g.va);
      hs  = !((cx >= g.ha + g.hfp) && (cx < g.ha + g.hfp + g.hsw));
      vs  = !((cy >= g.va + g.vfp) && (cy < g.va + g.vfp + g.vsw));
      bl  = act;
      if (act) begin
        rr = {rgb[7:5], rgb[7]};
        gc = {rgb[4:2], rgb[4]};
        bb = {rgb[1:0], rgb[1:0]};
      end
    end
    return {11'(x), 11'(y), sof, eol, rr, gc, bb, hs, vs, bl};
  endfunction

  task automatic check(input string tag, input vec_t obs, input vec_t exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s tick=%0d: got %h, expected %h", tag, tick, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s tick=%0d: got %0d, expected %0d", tag, tick, obs, exp);
    end
  endtask

  task automatic track_run(input string tag, input logic lvl, input int want, inout int run);
    if (lvl === 1'b0) run++;
    else if (run > 0) begin
      check_int(tag, run, want);
      run = 0;
    end
  endtask

  task automatic track_sof(input string tag, input logic sof, input int want, inout int last);
    if (sof === 1'b1) begin
      check_int(tag, tick - last, want);
      last = tick;
    end
  endtask

  task automatic step(input logic [7:0] rgb, input logic rst);
    rgb_in = rgb;
    reset  = rst;
    @(posedge clk);
    #1;
    if (rst) tick = 0;
    else tick++;
    check("main", obs_m, model(gm, tick, rgb));
    check("lat0", obs_s0, model(gs0, tick, rgb));
    check("lat3", obs_s3, model(gs3, tick, rgb));
    if (rst) begin
      hs_run = 0; vs_run0 = 0; vs_run3 = 0; sof_last0 = 0; sof_last3 = 0;
    end else begin
      track_run("hs_width", m_hs, 96, hs_run);
      track_run("vs_width0", s0_vs, 34, vs_run0);
      track_run("vs_width3", s3_vs, 34, vs_run3);
      track_sof("frame_len0", s0_sof, 170, sof_last0);
      track_sof("frame_len3", s3_sof, 170, sof_last3);
    end
  endtask

  initial begin
    tests = 0; fails = 0; tick = 0;
    hs_run = 0; vs_run0 = 0; vs_run3 = 0; sof_last0 = 0; sof_last3 = 0;
    gm  = '{ha: 640, hfp: 16, hsw: 96, hbp: 48, va: 480, vfp: 10, vsw: 2, vbp: 33, lat: 1};
    gs0 = '{ha: 10, hfp: 2, hsw: 3, hbp: 2, va: 6, vfp: 1, vsw: 2, vbp: 1, lat: 0};
    gs3 = '{ha: 10, hfp: 2, hsw: 3, hbp: 2, va: 6, vfp: 1, vsw: 2, vbp: 1, lat: 3};
    rgb_in = 8'h00;
    reset  = 1'b1;

    repeat (3) step(8'($urandom), 1'b1);
    check_int("sof_in_reset", int'(m_sof), 1);

    repeat (1600) step(8'($urandom), 1'b0);

    cnt_f = 0; cnt_0 = 0;
    repeat (800) begin
      step(8'hE0, 1'b0);
      if (m_r === 4'hF && m_g === 4'h0 && m_b === 4'h0) cnt_f++;
      else if (m_r === 4'h0) cnt_0++;
    end
    check_int("red_visible", cnt_f, 640);
    check_int("red_blank", cnt_0, 160);

    repeat (20) step(8'b001_010_11, 1'b0);
    check("expand", vec_t'({m_r, m_g, m_b}), vec_t'(12'b0010_0100_1111));

    for (int i = 0; i < 1000 && (tick % 800) != 700; i++) step(8'($urandom), 1'b0);
    check_int("reach_700", int'(m_px), 700);
    check_int("hs_low_700", int'(m_hs), 0);

    step(8'($urandom), 1'b1);
    check_int("hs_on_reset", int'(m_hs), 1);
    step(8'($urandom), 1'b1);
    step(8'($urandom), 1'b1);
    check_int("px_reset", int'(m_px), 0);

    repeat (700) step(8'($urandom), 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
